// File: rtl/bp_stats_monitor.sv
// Branch-prediction statistics: saturating live counters, snapshot on dump_req_i, 4-word valid/ready readout.
// Counts visible 1 cycle after the event; words held stable while stalled. Optional BP_STATS_HALT_DUMP_EN adds halt-triggered dump.
module bp_stats_monitor #(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_INSN = 32'h0000_006F
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             instr_vld_i,
  input  logic [31:0]      instr_i,
  input  logic             br_instr_i,
  input  logic             br_miss_i,
  input  logic             dump_req_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] out_data_o,
  output logic [1:0]       out_idx_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             orphan_o,
  output logic             halted_o
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d, br_q, br_d, miss_q, miss_d;
  logic [CNT_W-1:0] snap_q [4];
  logic [CNT_W-1:0] snap_d [4];
  logic             orphan_q, orphan_d, halted_q, halted_d;
  logic             cnt_en, halt_hit, dump_go;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

`ifdef BP_STATS_HALT_DUMP_EN
  // A halt freezes counting until clear_i; the halt cycle itself still counts.
  assign cnt_en   = enable_i && !halted_q;
  assign halt_hit = cnt_en && instr_vld_i && (instr_i == HALT_INSN);
`else
  logic unused_halt;
  assign cnt_en      = enable_i;
  assign halt_hit    = 1'b0;
  assign unused_halt = ^{instr_i, HALT_INSN};
`endif

  assign dump_go = dump_req_i || halt_hit;

  always_comb begin
    cyc_d    = sat_inc(cyc_q,  cnt_en);
    ins_d    = sat_inc(ins_q,  cnt_en && instr_vld_i);
    br_d     = sat_inc(br_q,   cnt_en && br_instr_i);
    miss_d   = sat_inc(miss_q, cnt_en && br_instr_i && br_miss_i);
    orphan_d = orphan_q || (cnt_en && br_miss_i && !br_instr_i);
    halted_d = halted_q || halt_hit;
    if (clear_i) begin
      cyc_d    = '0;
      ins_d    = '0;
      br_d     = '0;
      miss_d   = '0;
      orphan_d = 1'b0;
      halted_d = 1'b0;
    end
  end

  // Next-state: snapshot takes the post-update counter values of the request cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    for (int i = 0; i < 4; i++) snap_d[i] = snap_q[i];
    case (state_q)
      IDLE: begin
        if (dump_go) begin
          snap_d[0] = cyc_d;
          snap_d[1] = ins_d;
          snap_d[2] = br_d;
          snap_d[3] = miss_d;
          idx_d     = 2'd0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (out_ready_i) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q == SEND);
    busy_o      = (state_q == SEND);
    out_data_o  = (state_q == SEND) ? snap_q[idx_q] : '0;
    out_idx_o   = (state_q == SEND) ? idx_q : 2'd0;
    out_last_o  = (state_q == SEND) && (idx_q == 2'd3);
    orphan_o    = orphan_q;
    halted_o    = halted_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      cyc_q    <= '0;
      ins_q    <= '0;
      br_q     <= '0;
      miss_q   <= '0;
      orphan_q <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cyc_q    <= cyc_d;
      ins_q    <= ins_d;
      br_q     <= br_d;
      miss_q   <= miss_d;
      orphan_q <= orphan_d;
      halted_q <= halted_d;
      for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
    end
  end

endmodule

// File: tb/tb_bp_stats_monitor.sv
// Directed bench for bp_stats_monitor; a second CNT_W=4 instance shares the stimulus for saturation.
module tb_bp_stats_monitor;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst_i, enable_i, clear_i, instr_vld_i, br_instr_i, br_miss_i, dump_req_i, out_ready_i;
  logic [31:0] instr_i;
  logic        out_valid_o, out_last_o, busy_o, orphan_o, halted_o;
  logic [31:0] out_data_o;
  logic [1:0]  out_idx_o;
  logic        sat_valid, sat_last, sat_busy, sat_orphan, sat_halted;
  logic [3:0]  sat_data;
  logic [1:0]  sat_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bp_stats_monitor #(.CNT_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .instr_vld_i(instr_vld_i), .instr_i(instr_i), .br_instr_i(br_instr_i), .br_miss_i(br_miss_i),
    .dump_req_i(dump_req_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_idx_o(out_idx_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .orphan_o(orphan_o), .halted_o(halted_o)
  );

  bp_stats_monitor #(.CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .instr_vld_i(instr_vld_i), .instr_i(instr_i), .br_instr_i(br_instr_i), .br_miss_i(br_miss_i),
    .dump_req_i(dump_req_i), .out_valid_o(sat_valid), .out_ready_i(out_ready_i),
    .out_data_o(sat_data), .out_idx_o(sat_idx), .out_last_o(sat_last),
    .busy_o(sat_busy), .orphan_o(sat_orphan), .halted_o(sat_halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Request a dump with ready held high and check all four words.
  task automatic readout(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp_w [4];
    exp_w = '{e0, e1, e2, e3};
    out_ready_i = 1'b1;
    dump_req_i  = 1'b1;
    step();
    dump_req_i  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_w%0d_valid", tag, i), 32'(out_valid_o), 32'd1);
      check($sformatf("%s_w%0d_idx", tag, i), 32'(out_idx_o), 32'(i));
      check($sformatf("%s_w%0d_data", tag, i), out_data_o, exp_w[i]);
      check($sformatf("%s_w%0d_last", tag, i), 32'(out_last_o), 32'(i == 3));
      check($sformatf("%s_w%0d_busy", tag, i), 32'(busy_o), 32'd1);
      step();
    end
    check($sformatf("%s_end_valid", tag), 32'(out_valid_o), 32'd0);
    check($sformatf("%s_end_busy", tag), 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; instr_vld_i = 1'b0; instr_i = NOP;
    br_instr_i = 1'b0; br_miss_i = 1'b0; dump_req_i = 1'b0; out_ready_i = 1'b1;

    // Reset state
    repeat (2) step();
    check("rst_valid",  32'(out_valid_o), 32'd0);
    check("rst_data",   out_data_o, 32'd0);
    check("rst_idx",    32'(out_idx_o), 32'd0);
    check("rst_last",   32'(out_last_o), 32'd0);
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_orphan", 32'(orphan_o), 32'd0);
    check("rst_halted", 32'(halted_o), 32'd0);
    rst_i = 1'b0;

    // 10 enabled instruction cycles
    enable_i = 1'b1; instr_vld_i = 1'b1;
    repeat (10) step();
    enable_i = 1'b0; instr_vld_i = 1'b0;
    readout("t1", 32'd10, 32'd10, 32'd0, 32'd0);

    // Branches, misses and orphan misses
    clear_i = 1'b1; step(); clear_i = 1'b0;
    enable_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      br_instr_i = 1'b1; br_miss_i = (i < 3); step();
    end
    br_instr_i = 1'b0; br_miss_i = 1'b0;
    check("t2_orphan_before", 32'(orphan_o), 32'd0);
    br_miss_i = 1'b1; repeat (2) step();
    br_miss_i = 1'b0; enable_i = 1'b0;
    check("t2_orphan_after", 32'(orphan_o), 32'd1);
    readout("t2", 32'd10, 32'd0, 32'd8, 32'd3);

    // Stalled readout while counters keep running
    enable_i = 1'b1; instr_vld_i = 1'b1; dump_req_i = 1'b1;
    step();
    dump_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_w [4];
      exp_w = '{32'd11, 32'd1, 32'd8, 32'd3};
      out_ready_i = 1'b0;
      check($sformatf("t3_w%0d_idx", k), 32'(out_idx_o), 32'(k));
      check($sformatf("t3_w%0d_data", k), out_data_o, exp_w[k]);
      step();
      check($sformatf("t3_w%0d_idx_held", k), 32'(out_idx_o), 32'(k));
      check($sformatf("t3_w%0d_data_held", k), out_data_o, exp_w[k]);
      check($sformatf("t3_w%0d_last_held", k), 32'(out_last_o), 32'(k == 3));
      check($sformatf("t3_w%0d_valid_held", k), 32'(out_valid_o), 32'd1);
      out_ready_i = 1'b1;
      step();
    end
    enable_i = 1'b0; instr_vld_i = 1'b0;
    check("t3_end_valid", 32'(out_valid_o), 32'd0);
    readout("t3b", 32'd19, 32'd9, 32'd8, 32'd3);

    // Saturation on the 4-bit instance
    rst_i = 1'b1; step(); rst_i = 1'b0;
    enable_i = 1'b1; repeat (20) step(); enable_i = 1'b0;
    dump_req_i = 1'b1; step(); dump_req_i = 1'b0;
    check("t4_main_cyc", out_data_o, 32'd20);
    check("t4_sat_valid", 32'(sat_valid), 32'd1);
    check("t4_sat_cyc", 32'(sat_data), 32'd15);
    check("t4_sat_idx", 32'(sat_idx), 32'd0);
    check("t4_sat_last", 32'(sat_last), 32'd0);
    check("t4_sat_busy", 32'(sat_busy), 32'd1);
    check("t4_sat_orphan", 32'(sat_orphan), 32'd0);
    check("t4_sat_halted", 32'(sat_halted), 32'd0);
    repeat (4) step();
    check("t4_sat_end_valid", 32'(sat_valid), 32'd0);

    // Clear beats a same-cycle branch and clears the orphan flag
    enable_i = 1'b1; br_instr_i = 1'b1; repeat (2) step();
    br_instr_i = 1'b0; br_miss_i = 1'b1; step(); br_miss_i = 1'b0;
    check("t5_orphan_set", 32'(orphan_o), 32'd1);
    clear_i = 1'b1; br_instr_i = 1'b1; step();
    clear_i = 1'b0; br_instr_i = 1'b0; enable_i = 1'b0;
    check("t5_orphan_clr", 32'(orphan_o), 32'd0);
    readout("t5", 32'd0, 32'd0, 32'd0, 32'd0);

    // Reset during readout at idx 2
    enable_i = 1'b1; repeat (3) step(); enable_i = 1'b0;
    dump_req_i = 1'b1; step(); dump_req_i = 1'b0;
    repeat (2) step();
    check("t5r_idx2", 32'(out_idx_o), 32'd2);
    check("t5r_data2", out_data_o, 32'd0);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    check("t5r_valid", 32'(out_valid_o), 32'd0);
    check("t5r_busy", 32'(busy_o), 32'd0);
    readout("t5r", 32'd0, 32'd0, 32'd0, 32'd0);

    // Halt instruction
    rst_i = 1'b1; step(); rst_i = 1'b0;
    enable_i = 1'b1; instr_vld_i = 1'b1; instr_i = NOP;
    repeat (5) step();
    instr_i = HALT; step();
    instr_i = NOP; instr_vld_i = 1'b0;
`ifdef BP_STATS_HALT_DUMP_EN
    check("t6_halted", 32'(halted_o), 32'd1);
    check("t6_auto_valid", 32'(out_valid_o), 32'd1);
    check("t6_auto_cyc", out_data_o, 32'd6);
    step();
    check("t6_auto_ins", out_data_o, 32'd6);
    repeat (6) step();
    enable_i = 1'b0;
    readout("t6", 32'd6, 32'd6, 32'd0, 32'd0);
    check("t6_halted_end", 32'(halted_o), 32'd1);
`else
    check("t6_halted", 32'(halted_o), 32'd0);
    check("t6_no_valid", 32'(out_valid_o), 32'd0);
    step();
    check("t6_no_valid2", 32'(out_valid_o), 32'd0);
    repeat (6) step();
    enable_i = 1'b0;
    readout("t6", 32'd13, 32'd6, 32'd0, 32'd0);
    check("t6_halted_end", 32'(halted_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_stats_monitor.md
# bp_stats_monitor

Branch-prediction statistics collector for the pipelined core benches. It consumes the per-cycle probe signals the bench top exports from any predictor variant (always-taken, two-bit, gshare, agree): fetched instruction, branch-resolved strobe and misprediction strobe. It accumulates cycle, instruction, branch and miss counts in saturating counters. On request, it snapshots the counts and streams them out as four words over a valid/ready port.

## Interface
Parameters:
- CNT_W, 32: width of every counter and of the readout word.
- HALT_INSN, 32'h0000_006F: instruction encoding (`jal x0, 0`) treated as program end; used only with the halt-dump feature.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  counting window; no counter advances while low.
- clear_i  in  1  zero all live counters and sticky flags.
- instr_vld_i  in  1  instr_i holds a fetched instruction this cycle.
- instr_i  in  32  fetched instruction word.
- br_instr_i  in  1  a branch/jump resolved this cycle.
- br_miss_i  in  1  a misprediction flush occurred this cycle.
- dump_req_i  in  1  request a snapshot readout (level-sampled).
- out_valid_o  out  1  readout word valid.
- out_ready_i  in  1  sink accepts word.
- out_data_o  out  CNT_W  readout word.
- out_idx_o  out  2  word index: 0 cycles, 1 instructions, 2 branches, 3 misses.
- out_last_o  out  1  high with idx 3.
- busy_o  out  1  readout in progress.
- orphan_o  out  1  sticky: br_miss_i seen without br_instr_i.
- halted_o  out  1  sticky: HALT_INSN fetched (feature-dependent).

## Operation
- Live counters:
  - cyc_cnt increments every enabled cycle.
  - ins_cnt increments when instr_vld_i is high.
  - br_cnt increments when br_instr_i is high.
  - miss_cnt increments when br_instr_i and br_miss_i are both high.
  - All counts are gated by enable_i. Each counter saturates at all-ones and never wraps.
- A br_miss_i without br_instr_i counts nothing and sets orphan_o while enable_i is high.
- clear_i has priority over any same-cycle increment. The result is 0 and the event is dropped. clear_i also clears orphan_o and halted_o. It does not touch snapshot registers or an ongoing readout.
- FSM states:
  - IDLE:
    - dump_req_i high → load the four snapshot registers with the counter values *including* events sampled this cycle (the post-update values).
    - Set idx = 0 and go to SEND.
  - SEND:
    - out_valid_o = 1; out_data_o = snapshot[idx].
    - On out_valid_o && out_ready_i: idx++.
    - At idx 3 the handshake returns the FSM to IDLE.
    - dump_req_i is ignored while in SEND.
- Live counters keep counting during SEND; the snapshot is frozen.
- busy_o = (state == SEND).

## Timing
- Reset (rst_i sampled high): all counters 0, snapshots 0, state IDLE. All outputs 0: out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, orphan_o, halted_o.
- Reset mid-readout aborts it: out_valid_o is 0 the next cycle.
- Counter update latency: 1 cycle (value visible the cycle after the event).
- Readout latency: out_valid_o rises 1 cycle after the sampled dump_req_i.
- With out_ready_i held high, the full readout takes 4 cycles and busy_o stays high for 4 cycles.
- While out_valid_o && !out_ready_i, out_data_o, out_idx_o and out_last_o are held stable.
- A new request in the cycle the FSM returns to IDLE is honoured one cycle later. Minimum gap between readouts: 1 cycle.

## Configuration
- BP_STATS_HALT_DUMP_EN defined:
  - An enabled cycle with instr_vld_i && instr_i == HALT_INSN sets halted_o.
  - Counting then freezes (as if enable_i = 0) until clear_i.
  - If the FSM is in IDLE, it triggers a readout exactly as dump_req_i would. The halt cycle's own events are included.
  - A halt seen during SEND sets halted_o but does not start a second readout.
- Not defined: halted_o is tied 0, HALT_INSN is ignored, and no auto-dump occurs.

## Test plan
- Reset, then 10 enabled cycles with instr_vld_i = 1, no branches, then dump with ready = 1 → words 10, 10, 0, 0 on idx 0..3. out_last_o is high only on idx 3; busy_o is high for 4 cycles.
- 8 branches, 3 of them with br_miss_i, plus 2 br_miss_i pulses without br_instr_i → br = 8, miss = 3, orphan_o = 1.
- Dump with out_ready_i toggling 1/0 → each word held stable while stalled, all 4 words delivered in order. Counters keep advancing, and a second dump shows the larger values.
- CNT_W = 4, 20 enabled cycles → cycle word = 15 (saturated, no wrap).
- clear_i asserted in the same cycle as br_instr_i → br_cnt = 0 next cycle. rst_i asserted during SEND at idx 2 → out_valid_o = 0 next cycle, all counters 0.
- With BP_STATS_HALT_DUMP_EN, fetch 5 NOPs then HALT_INSN → halted_o = 1, auto readout gives instruction word 6, and counts stay frozen afterwards. Without the macro, the same stimulus produces no readout and halted_o = 0.
